// File: rtl/cpu_types_pkg.sv
// Shared types for the branch target predictor.
//   bpred_ctr_t            : 2-bit direction counter states
//   bpred_entry_t          : one table entry {valid, tag, target, ctr}
//   BPRED_DEFAULT_ENTRIES  : default table depth
//   BPRED_TAG_MAX_W        : stored tag field width (covers the ENTRIES = 2 case)
//   pc_plus4()             : 32-bit modulo sequential-PC helper
package cpu_types_pkg;

  localparam int BPRED_DEFAULT_ENTRIES = 16;
  // The struct cannot depend on ENTRIES, so the tag field is sized for the
  // smallest legal table; narrower tags are stored zero-extended.
  localparam int BPRED_TAG_MAX_W = 29;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } bpred_ctr_t;

  typedef struct packed {
    logic                       valid;
    logic [BPRED_TAG_MAX_W-1:0] tag;
    logic [31:0]                target;
    bpred_ctr_t                 ctr;
  } bpred_entry_t;

  // Wraps 0xFFFFFFFC to 0x00000000.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch/memory-stage signal bundle for branch_target_predictor.
//   master : core side (drives fetch PC and resolution info)
//   slave  : predictor side (drives prediction, mispredict, corrected PC, stats)
interface branch_target_predictor_if;
  // fetch stage
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  // memory-stage resolution
  logic        m_en;
  logic        m_update;
  logic        m_uncond;
  logic [31:0] m_pc;
  logic        m_taken;
  logic [31:0] m_target;
  logic        m_pred_taken;
  logic [31:0] m_pred_target;
  logic        m_mispredict;
  logic [31:0] m_correct_pc;
  // statistics (zero unless BPRED_STATS_EN)
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output f_pc, m_en, m_update, m_uncond, m_pc, m_taken, m_target,
           m_pred_taken, m_pred_target,
    input  f_pred_taken, f_pred_target, m_mispredict, m_correct_pc,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  f_pc, m_en, m_update, m_uncond, m_pc, m_taken, m_target,
           m_pred_taken, m_pred_target,
    output f_pred_taken, f_pred_target, m_mispredict, m_correct_pc,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/bpred_counter.sv
// 2-bit saturating direction counter next-state logic.
//   ctr          in  : current counter state
//   taken        in  : resolved direction (step up when 1, down when 0)
//   force_strong in  : unconditional jump, jump straight to STRONG_T
//   ctr_next     out : next counter state
module bpred_counter
  import cpu_types_pkg::*;
(
  input  bpred_ctr_t ctr,
  input  logic       taken,
  input  logic       force_strong,
  output bpred_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (force_strong) begin
      ctr_next = STRONG_T;
    end else if (taken) begin
      if (ctr != STRONG_T) ctr_next = bpred_ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != STRONG_NT) ctr_next = bpred_ctr_t'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Branch target buffer with per-entry 2-bit direction counters.
// Fetch lookup is combinational; memory-stage resolution updates the table
// on the rising edge and produces the mispredict flag / corrected PC.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : branch_target_predictor_if.slave (fetch + memory-stage signals)
// Optional feature: define BPRED_STATS_EN to build the branch/mispredict
// statistics counters; otherwise the stat outputs read zero.
module branch_target_predictor
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES = BPRED_DEFAULT_ENTRIES
) (
  input logic                       CLK,
  input logic                       RST,
  branch_target_predictor_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  bpred_entry_t table_q [ENTRIES];
  bpred_entry_t table_d [ENTRIES];

  // ---------------- fetch lookup ----------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  bpred_entry_t     f_entry;
  logic             f_hit;

  assign f_idx   = bus.f_pc[IDX_W+1:2];
  assign f_tag   = bus.f_pc[31:IDX_W+2];
  assign f_entry = table_q[f_idx];
  assign f_hit   = f_entry.valid && (f_entry.tag == BPRED_TAG_MAX_W'(f_tag));

  // Gate with RST so no stale entry predicts before the clearing edge.
  assign bus.f_pred_taken  = !RST && f_hit && (f_entry.ctr >= WEAK_T);
  assign bus.f_pred_target = bus.f_pred_taken ? f_entry.target : pc_plus4(bus.f_pc);

  // ---------------- memory-stage resolution ----------------
  assign bus.m_mispredict = bus.m_update &
                            ((bus.m_taken != bus.m_pred_taken) |
                             (bus.m_taken & bus.m_pred_taken &
                              (bus.m_target != bus.m_pred_target)));
  assign bus.m_correct_pc = bus.m_taken ? bus.m_target : pc_plus4(bus.m_pc);

  logic             upd_en;
  logic             upd_write;
  logic [IDX_W-1:0] m_idx;
  logic [TAG_W-1:0] m_tag;
  bpred_entry_t     m_entry;
  logic             m_hit;
  bpred_ctr_t       cur_ctr;
  bpred_ctr_t       ctr_next;

  assign upd_en    = bus.m_update & bus.m_en;
  assign upd_write = bus.m_taken | bus.m_uncond;
  assign m_idx     = bus.m_pc[IDX_W+1:2];
  assign m_tag     = bus.m_pc[31:IDX_W+2];
  assign m_entry   = table_q[m_idx];
  assign m_hit     = m_entry.valid && (m_entry.tag == BPRED_TAG_MAX_W'(m_tag));

  // A miss is treated as starting from WEAK_NT: one taken step lands on
  // WEAK_T and force_strong lands on STRONG_T, which is exactly the
  // allocation value, so a single counter instance covers both paths.
  assign cur_ctr = m_hit ? m_entry.ctr : WEAK_NT;

  bpred_counter u_counter (
    .ctr          (cur_ctr),
    .taken        (bus.m_taken),
    .force_strong (bus.m_uncond),
    .ctr_next     (ctr_next)
  );

  always_comb begin
    table_d = table_q;
    if (upd_en) begin
      if (m_hit) begin
        table_d[m_idx].ctr = ctr_next;
        if (upd_write) table_d[m_idx].target = bus.m_target;
      end else if (upd_write) begin
        table_d[m_idx] = '{valid:  1'b1,
                           tag:    BPRED_TAG_MAX_W'(m_tag),
                           target: bus.m_target,
                           ctr:    ctr_next};
      end
    end
  end

  // Tag and target are intentionally left out of reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
        table_q[i].ctr   <= WEAK_NT;
      end
    end else begin
      table_q <= table_d;
    end
  end

  // ---------------- statistics ----------------
`ifdef BPRED_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_en) begin
      if (stat_branches_q != '1) stat_branches_d = stat_branches_q + 32'd1;
      if (bus.m_mispredict && (stat_mispredicts_q != '1))
        stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
`else
  assign bus.stat_branches    = '0;
  assign bus.stat_mispredicts = '0;
`endif

  // Byte-offset bits of word-aligned PCs carry no information here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.f_pc[1:0], bus.m_pc[1:0]};

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed scenarios plus a
// randomized run against a table-level reference model.
module tb_branch_target_predictor;
  import cpu_types_pkg::*;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_target_predictor_if bif ();

  branch_target_predictor #(.ENTRIES(ENTRIES)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bif)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference model: what each table slot remembers
  bit          mv   [ENTRIES];
  int unsigned mtag [ENTRIES];
  int unsigned mtgt [ENTRIES];
  int          mctr [ENTRIES];
  int unsigned m_branches;
  int unsigned m_mispred;

  function automatic int unsigned idx_of(input int unsigned pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc >> (2 + IDX_W);
  endfunction

  function automatic bit model_taken(input int unsigned pc);
    int unsigned i;
    i = idx_of(pc);
    return mv[i] && (mtag[i] == tag_of(pc)) && (mctr[i] >= 2);
  endfunction

  function automatic int unsigned model_target(input int unsigned pc);
    return model_taken(pc) ? mtgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit exp_misp(input bit taken, input bit ptaken,
                                  input int unsigned tgt, input int unsigned ptgt);
    return (taken != ptaken) || (taken && ptaken && (tgt != ptgt));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      mv[i]   = 1'b0;
      mctr[i] = 1;
    end
    m_branches = 0;
    m_mispred  = 0;
  endtask

  task automatic model_update(input int unsigned pc, input bit taken, input bit uncond,
                              input int unsigned tgt, input bit misp);
    int unsigned i;
    bit hit;
    i   = idx_of(pc);
    hit = mv[i] && (mtag[i] == tag_of(pc));
    if (hit) begin
      if (uncond) begin
        mctr[i] = 3;
        mtgt[i] = tgt;
      end else if (taken) begin
        mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
        mtgt[i] = tgt;
      end else begin
        mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
      end
    end else if (taken || uncond) begin
      mv[i]   = 1'b1;
      mtag[i] = tag_of(pc);
      mtgt[i] = tgt;
      mctr[i] = uncond ? 3 : 2;
    end
    if (m_branches != 32'hFFFFFFFF) m_branches++;
    if (misp && (m_mispred != 32'hFFFFFFFF)) m_mispred++;
  endtask

  // Starts and ends at posedge+1. Samples combinational outputs at negedge,
  // then lets the edge apply the update and mirrors it in the model.
  task automatic drive_update(input logic [31:0] pc, input bit taken, input bit uncond,
                              input logic [31:0] tgt, input bit ptaken,
                              input logic [31:0] ptgt, input bit en,
                              output bit obs_misp, output logic [31:0] obs_corr);
    bif.m_pc          = pc;
    bif.m_taken       = taken;
    bif.m_uncond      = uncond;
    bif.m_target      = tgt;
    bif.m_pred_taken  = ptaken;
    bif.m_pred_target = ptgt;
    bif.m_update      = 1'b1;
    bif.m_en          = en;
    @(negedge clk);
    obs_misp = bif.m_mispredict;
    obs_corr = bif.m_correct_pc;
    @(posedge clk);
    if (en) model_update(pc, taken, uncond, tgt, exp_misp(taken, ptaken, tgt, ptgt));
    #1;
    bif.m_update = 1'b0;
    bif.m_en     = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    bif.f_pc = pc;
    #1;
    t  = bif.f_pred_taken;
    tg = bif.f_pred_target;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bif.f_pc = 32'h0; bif.m_en = 1'b0; bif.m_update = 1'b0; bif.m_uncond = 1'b0;
    bif.m_pc = 32'h0; bif.m_taken = 1'b0; bif.m_target = 32'h0;
    bif.m_pred_taken = 1'b0; bif.m_pred_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bif.f_pc = 32'h40;
    bif.m_taken = 1'b1;
    #1;
    vectors++;
    if (bif.f_pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL reset_pred_taken: got %b want 0", bif.f_pred_taken);
    end
    vectors++;
    if (bif.f_pred_target !== 32'h44) begin
      miscompares++; $display("FAIL reset_pred_target: got %h want 00000044", bif.f_pred_target);
    end
    vectors++;
    if (bif.stat_branches !== 32'h0 || bif.stat_mispredicts !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_stats: got %0d/%0d want 0/0", bif.stat_branches, bif.stat_mispredicts);
    end
    vectors++;
    if (bif.m_mispredict !== 1'b0) begin
      miscompares++; $display("FAIL idle_misp: got %b want 0 (m_update low)", bif.m_mispredict);
    end
    bif.m_taken = 1'b0;
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_allocate();
    bit m; logic [31:0] c; bit t; logic [31:0] g;
    drive_update(32'h40, 1, 0, 32'h100, 0, 32'h44, 1, m, c);
    vectors++;
    if (m !== 1'b1) begin miscompares++; $display("FAIL alloc_misp: got %b want 1", m); end
    vectors++;
    if (c !== 32'h100) begin miscompares++; $display("FAIL alloc_corr: got %h want 00000100", c); end
    do_lookup(32'h40, t, g);
    vectors++;
    if (t !== 1'b1 || g !== 32'h100) begin
      miscompares++; $display("FAIL alloc_predict: got %b/%h want 1/00000100", t, g);
    end
    $display("test_allocate done");
  endtask

  task automatic test_hysteresis();
    bit m; logic [31:0] c; bit t; logic [31:0] g;
    drive_update(32'h40, 0, 0, 32'h100, 1, 32'h100, 1, m, c);
    vectors++;
    if (m !== 1'b1 || c !== 32'h44) begin
      miscompares++; $display("FAIL hyst_nt1: got %b/%h want 1/00000044", m, c);
    end
    drive_update(32'h40, 0, 0, 32'h100, 1, 32'h100, 1, m, c);
    do_lookup(32'h40, t, g);
    vectors++;
    if (t !== 1'b0 || g !== 32'h44) begin
      miscompares++; $display("FAIL hyst_strong_nt: got %b/%h want 0/00000044", t, g);
    end
    drive_update(32'h40, 1, 0, 32'h100, 0, 32'h44, 1, m, c);
    do_lookup(32'h40, t, g);
    vectors++;
    if (t !== 1'b0 || g !== 32'h44) begin
      miscompares++; $display("FAIL hyst_weak_nt: got %b/%h want 0/00000044", t, g);
    end
    $display("test_hysteresis done");
  endtask

  task automatic test_aliasing();
    bit m; logic [31:0] c; bit t; logic [31:0] g;
    drive_update(32'h40, 1, 0, 32'h140, 0, 32'h44, 1, m, c);
    drive_update(32'h80, 1, 0, 32'h180, 0, 32'h84, 1, m, c);
    do_lookup(32'h40, t, g);
    vectors++;
    if (t !== 1'b0 || g !== 32'h44) begin
      miscompares++; $display("FAIL alias_evicted: got %b/%h want 0/00000044", t, g);
    end
    do_lookup(32'h80, t, g);
    vectors++;
    if (t !== 1'b1 || g !== 32'h180) begin
      miscompares++; $display("FAIL alias_new: got %b/%h want 1/00000180", t, g);
    end
    $display("test_aliasing done");
  endtask

  task automatic test_jr();
    bit m; logic [31:0] c; bit t; logic [31:0] g;
    drive_update(32'h40, 1, 1, 32'h300, 1, 32'h200, 1, m, c);
    vectors++;
    if (m !== 1'b1 || c !== 32'h300) begin
      miscompares++; $display("FAIL jr_misp: got %b/%h want 1/00000300", m, c);
    end
    do_lookup(32'h40, t, g);
    vectors++;
    if (t !== 1'b1 || g !== 32'h300) begin
      miscompares++; $display("FAIL jr_target: got %b/%h want 1/00000300", t, g);
    end
    drive_update(32'h40, 1, 1, 32'h500, 1, 32'h200, 0, m, c);
    vectors++;
    if (m !== 1'b1 || c !== 32'h500) begin
      miscompares++; $display("FAIL jr_noen_misp: got %b/%h want 1/00000500", m, c);
    end
    do_lookup(32'h40, t, g);
    vectors++;
    if (t !== 1'b1 || g !== 32'h300) begin
      miscompares++; $display("FAIL jr_noen_frozen: got %b/%h want 1/00000300", t, g);
    end
    // one not-taken step from STRONG_T must still predict taken
    drive_update(32'h40, 0, 0, 32'h0, 1, 32'h300, 1, m, c);
    do_lookup(32'h40, t, g);
    vectors++;
    if (t !== 1'b1 || g !== 32'h300) begin
      miscompares++; $display("FAIL jr_strong: got %b/%h want 1/00000300", t, g);
    end
    $display("test_jr done");
  endtask

  task automatic test_back_to_back();
    bit m; logic [31:0] c; bit t; logic [31:0] g;
    bit          seq_t [7] = '{1, 0, 0, 1, 1, 1, 0};
    logic [31:0] seq_g [7] = '{32'h600, 32'h0, 32'h0, 32'h610, 32'h620, 32'h630, 32'h0};
    for (int k = 0; k < 4; k++) begin
      drive_update(32'h2004, seq_t[k], 0, seq_g[k], 0, 32'h2008, 1, m, c);
      vectors++;
      if (m !== seq_t[k]) begin
        miscompares++; $display("FAIL b2b_misp%0d: got %b want %b", k, m, seq_t[k]);
      end
    end
    do_lookup(32'h2004, t, g);
    vectors++;
    if (t !== 1'b0 || g !== 32'h2008) begin
      miscompares++; $display("FAIL b2b_weak_nt: got %b/%h want 0/00002008", t, g);
    end
    for (int k = 4; k < 7; k++) drive_update(32'h2004, seq_t[k], 0, seq_g[k], 0, 32'h2008, 1, m, c);
    do_lookup(32'h2004, t, g);
    vectors++;
    if (t !== 1'b1 || g !== 32'h630) begin
      miscompares++; $display("FAIL b2b_weak_t: got %b/%h want 1/00000630", t, g);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_read_during_write();
    bit t; logic [31:0] g;
    bif.f_pc = 32'h3008;
    bif.m_pc = 32'h3008; bif.m_taken = 1'b1; bif.m_uncond = 1'b0;
    bif.m_target = 32'h400; bif.m_pred_taken = 1'b0; bif.m_pred_target = 32'h300C;
    bif.m_update = 1'b1; bif.m_en = 1'b1;
    @(negedge clk);
    vectors++;
    if (bif.f_pred_taken !== 1'b0 || bif.f_pred_target !== 32'h300C) begin
      miscompares++;
      $display("FAIL rdw_pre: got %b/%h want 0/0000300c", bif.f_pred_taken, bif.f_pred_target);
    end
    @(posedge clk);
    model_update(32'h3008, 1, 0, 32'h400, 1);
    #1;
    bif.m_update = 1'b0; bif.m_en = 1'b0;
    do_lookup(32'h3008, t, g);
    vectors++;
    if (t !== 1'b1 || g !== 32'h400) begin
      miscompares++; $display("FAIL rdw_post: got %b/%h want 1/00000400", t, g);
    end
    $display("test_read_during_write done");
  endtask

  task automatic test_midreset();
    bit m; logic [31:0] c; bit t; logic [31:0] g;
    drive_update(32'h500, 1, 0, 32'h900, 0, 32'h504, 1, m, c);
    do_lookup(32'h500, t, g);
    vectors++;
    if (t !== 1'b1 || g !== 32'h900) begin
      miscompares++; $display("FAIL mrst_before: got %b/%h want 1/00000900", t, g);
    end
    rst = 1'b1;
    bif.f_pc = 32'h500;
    bif.m_update = 1'b1; bif.m_en = 1'b0; bif.m_taken = 1'b1; bif.m_pred_taken = 1'b0;
    bif.m_target = 32'h900;
    #1;
    vectors++;
    if (bif.f_pred_taken !== 1'b0 || bif.f_pred_target !== 32'h504) begin
      miscompares++;
      $display("FAIL mrst_during: got %b/%h want 0/00000504", bif.f_pred_taken, bif.f_pred_target);
    end
    vectors++;
    if (bif.m_mispredict !== 1'b1) begin
      miscompares++; $display("FAIL mrst_misp: got %b want 1", bif.m_mispredict);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bif.m_update = 1'b0;
    model_reset();
    do_lookup(32'h500, t, g);
    vectors++;
    if (t !== 1'b0 || g !== 32'h504) begin
      miscompares++; $display("FAIL mrst_after: got %b/%h want 0/00000504", t, g);
    end
    vectors++;
    if (bif.stat_branches !== 32'h0 || bif.stat_mispredicts !== 32'h0) begin
      miscompares++;
      $display("FAIL mrst_stats: got %0d/%0d want 0/0", bif.stat_branches, bif.stat_mispredicts);
    end
    $display("test_midreset done");
  endtask

  task automatic test_stats();
    bit m; logic [31:0] c;
    int unsigned want_b, want_m;
    for (int i = 0; i < 10; i++) begin
      if (i < 3) drive_update(32'h1000 + 32'(i * 4), 1, 0, 32'h700, 0, 32'h0, 1, m, c);
      else       drive_update(32'h1000 + 32'(i * 4), 0, 0, 32'h700, 0, 32'h0, 1, m, c);
    end
    // mispredicted but unqualified: must not count
    drive_update(32'h1100, 1, 0, 32'h700, 0, 32'h0, 0, m, c);
`ifdef BPRED_STATS_EN
    want_b = 10; want_m = 3;
`else
    want_b = 0;  want_m = 0;
`endif
    vectors++;
    if (bif.stat_branches !== want_b) begin
      miscompares++; $display("FAIL stat_branches: got %0d want %0d", bif.stat_branches, want_b);
    end
    vectors++;
    if (bif.stat_mispredicts !== want_m) begin
      miscompares++; $display("FAIL stat_mispredicts: got %0d want %0d", bif.stat_mispredicts, want_m);
    end
    $display("test_stats done");
  endtask

  task automatic test_wrap();
    bit m; logic [31:0] c; bit t; logic [31:0] g;
    do_lookup(32'hFFFFFFFC, t, g);
    vectors++;
    if (t !== 1'b0 || g !== 32'h0) begin
      miscompares++; $display("FAIL wrap_lookup: got %b/%h want 0/00000000", t, g);
    end
    drive_update(32'hFFFFFFFC, 0, 0, 32'h1234, 0, 32'h0, 0, m, c);
    vectors++;
    if (m !== 1'b0 || c !== 32'h0) begin
      miscompares++; $display("FAIL wrap_corr: got %b/%h want 0/00000000", m, c);
    end
    $display("test_wrap done");
  endtask

  task automatic test_random();
    bit m; logic [31:0] c; bit t; logic [31:0] g;
    int unsigned tags [4] = '{0, 1, 2, 32'h3FFFFFF};
    int unsigned pc, lpc, tgt, ptgt;
    bit taken, uncond, ptaken, en, em;
    int unsigned ec;
    for (int n = 0; n < 400; n++) begin
      lpc = (tags[$urandom_range(0, 3)] << 6) | ($urandom_range(0, 15) << 2);
      do_lookup(lpc, t, g);
      vectors++;
      if (t !== model_taken(lpc) || g !== model_target(lpc)) begin
        miscompares++;
        $display("FAIL rnd_lookup[%0d] pc=%h: got %b/%h want %b/%h", n, lpc, t, g,
                 model_taken(lpc), model_target(lpc));
      end
      pc     = (tags[$urandom_range(0, 3)] << 6) | ($urandom_range(0, 15) << 2);
      uncond = ($urandom_range(0, 4) == 0);
      taken  = uncond ? 1'b1 : 1'($urandom_range(0, 1));
      tgt    = $urandom & 32'hFFFFFFFC;
      if ($urandom_range(0, 1) == 1) begin
        ptaken = model_taken(pc);
        ptgt   = model_target(pc);
      end else begin
        ptaken = 1'($urandom_range(0, 1));
        ptgt   = ($urandom_range(0, 1) == 1) ? tgt : ($urandom & 32'hFFFFFFFC);
      end
      en = ($urandom_range(0, 9) != 0);
      em = exp_misp(taken, ptaken, tgt, ptgt);
      ec = taken ? tgt : pc + 32'd4;
      drive_update(pc, taken, uncond, tgt, ptaken, ptgt, en, m, c);
      vectors++;
      if (m !== em || c !== ec) begin
        miscompares++;
        $display("FAIL rnd_update[%0d] pc=%h: got %b/%h want %b/%h", n, pc, m, c, em, ec);
      end
    end
`ifdef BPRED_STATS_EN
    vectors++;
    if (bif.stat_branches !== m_branches || bif.stat_mispredicts !== m_mispred) begin
      miscompares++;
      $display("FAIL rnd_stats: got %0d/%0d want %0d/%0d", bif.stat_branches,
               bif.stat_mispredicts, m_branches, m_mispred);
    end
`endif
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_hysteresis();
    test_aliasing();
    test_jr();
    test_back_to_back();
    test_read_during_write();
    test_midreset();
    test_stats();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch target buffer with per-entry 2-bit saturating direction counters for the pipelined MIPS core. During fetch it supplies a predicted next PC. Branches and jumps resolve in the memory stage. The block is updated from that resolution and computes the mispredict flag and the corrected PC, so the datapath flushes only on a wrong prediction instead of on every taken branch.

## Interface
- ENTRIES, 16, number of table entries; power of two, ≥ 2; IDX_W = $clog2(ENTRIES)
- TAG_W, 30 − IDX_W, tag width taken from PC[31:IDX_W+2]
- CLK  in  1  core clock; all state updates on rising edge
- RST  in  1  reset; synchronous, active-high
- f_pc  in  32  PC currently being fetched
- f_pred_taken  out  1  fetch-stage prediction: entry valid, tag match, and counter ≥ WEAK_T
- f_pred_target  out  32  predicted target when f_pred_taken; otherwise f_pc + 4
- m_en  in  1  pipeline advance qualifier from the hazard unit; no update without it
- m_update  in  1  memory-stage instruction is a branch or jump
- m_uncond  in  1  memory-stage instruction is j, jal or jr
- m_pc  in  32  PC of the resolving instruction
- m_taken  in  1  actual direction
- m_target  in  32  actual target address (baddr, jaddr or rdat1)
- m_pred_taken  in  1  prediction carried down the pipeline with the instruction
- m_pred_target  in  32  predicted target carried with the instruction
- m_mispredict  out  1  combinational; flush request
- m_correct_pc  out  32  m_taken ? m_target : m_pc + 4
- stat_branches  out  32  resolved-branch count (macro only)
- stat_mispredicts  out  32  mispredict count (macro only)

## Operation
- Each entry holds: valid, tag[TAG_W], target[32], ctr[2]. The counter encoding is STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3.
- Lookup is combinational. idx = f_pc[IDX_W+1:2] and tag = f_pc[31:IDX_W+2].
- m_mispredict = m_update & ((m_taken ≠ m_pred_taken) | (m_taken & m_pred_taken & m_target ≠ m_pred_target)).
- m_mispredict is independent of m_en. The hazard unit qualifies it.
- An update happens only when m_update & m_en.
- **Hit, taken:** increment ctr, saturating at 3. Overwrite target.
- **Hit, not-taken:** decrement ctr, saturating at 0. Target is unchanged.
- **Hit, m_uncond:** force ctr = STRONG_T and write the target.
- **Miss, taken:** allocate the entry and overwrite whatever is there. Write valid=1, tag, target, and ctr = WEAK_T. For m_uncond, write ctr = STRONG_T instead.
- **Miss, not-taken:** no allocation and no change.
- Address arithmetic: all PC + 4 adds are 32-bit modulo. Wrap from 0xFFFFFFFC gives 0x00000000.

## Timing
- Prediction latency is 0 cycles. The f_* outputs are valid in the same cycle as f_pc.
- Updates become visible at the next rising edge.
- Read-during-write: if f_pc maps to the entry being updated in the same cycle, the lookup returns the pre-update contents.
- Back-to-back updates to the same index on consecutive cycles each apply in order. The counter moves one step per cycle.
- Reset, including mid-operation (RST high for ≥ 1 edge):
  - all valid bits clear, so no prediction is made;
  - ctr resets to WEAK_NT;
  - stat counters reset to 0.
- Tag and target fields are not reset.
- While RST is high, f_pred_taken = 0 and f_pred_target = f_pc + 4. m_* outputs stay combinational from their inputs.
- m_en low freezes all state, including the stat counters.

## Configuration
- BPRED_STATS_EN defined:
  - stat_branches increments on every qualified update;
  - stat_mispredicts increments on every qualified update where m_mispredict = 1;
  - both saturate at 0xFFFFFFFF.
- BPRED_STATS_EN undefined: no counter flops; both stat outputs are tied to 0. The ports stay present so that the top-level wiring does not change.

## Structure
- Add to cpu_types_pkg:
  - bpred_ctr_t, an enum of the four counter states;
  - bpred_entry_t, a packed struct {valid, tag, target, ctr};
  - BPRED_DEFAULT_ENTRIES = 16.
- Sub-module bpred_counter is the 2-bit saturating next-state logic: inputs ctr, taken, force_strong; output next ctr. It is instantiated once on the update path.
- The table is a flop array, not SRAM, which keeps the read combinational.

## Test plan
- **Reset and cold lookup:** assert RST for 2 cycles, then f_pc = 0x00000040 → f_pred_taken = 0, f_pred_target = 0x00000044, stats = 0.
- **Allocate then predict:** update m_pc = 0x40, taken, m_target = 0x100, m_pred_taken = 0 → m_mispredict = 1, m_correct_pc = 0x100. On the next cycle, f_pc = 0x40 → taken, target 0x100.
- **Counter hysteresis:** two not-taken updates at 0x40 (WEAK_T → WEAK_NT → STRONG_NT) → prediction not-taken. One taken update → still not-taken (WEAK_NT).
- **Aliasing, ENTRIES = 16:** allocate 0x40, then taken at 0x80. 0x80 has the same index but a different tag → lookup of 0x40 misses, 0x80 hits.
- **Target mismatch and jr:** m_uncond, taken, m_pred_target = 0x200, m_target = 0x300 → m_mispredict = 1 and the entry target becomes 0x300 with STRONG_T. With m_en = 0, the same stimulus leaves the table unchanged.
- **Stats with BPRED_STATS_EN:** 10 updates, 3 mispredicted → stat_branches = 10, stat_mispredicts = 3. Without the macro, both read 0.
